if_id_skid_stage: RTL and testbench

Parametrised IF/ID pipeline stage with a valid/ready handshake and a two-entry skid buffer. It replaces the single-register IF/ID latch and its global `pause` input. Back-pressure from decode is absorbed for one extra cycle without combinational ready paths, and a flush drops in-flight instructions. The block sits between instruction fetch (upstream) and decode (downstream). It also keeps a saturating stall counter for performance monitoring.

---
 rtl/if_id_skid_stage.sv | 119 +++++++++++
 tb/tb_if_id_skid_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake over a two-entry (main + skid) buffer, with flush
// and a saturating stall counter. in_ready is registered, so no combinational input-to-output paths.
module if_id_skid_stage #(
  parameter int                DATA_W = 32,
  parameter int                PC_W   = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_inst_q, main_inst_d;
  logic [PC_W-1:0]     main_pc_q, main_pc_d;
  logic [DATA_W-1:0]   skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                accept;
  logic                pop;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_inst_d = in_inst;
            main_pc_d   = in_pc;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_inst_d = in_inst;
            main_pc_d   = in_pc;
          end else if (accept) begin
            skid_inst_d = in_inst;
            skid_pc_d   = in_pc;
            state_d     = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state
          if (pop) begin
            main_inst_d = skid_inst_q;
            main_pc_d   = skid_pc_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready_d  = (state_d != FULL);
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_inst_q <= BUBBLE;
      main_pc_q   <= '0;
      skid_inst_q <= BUBBLE;
      skid_pc_q   <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_inst_q <= main_inst_d;
      main_pc_q   <= main_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Invalid main entry is masked so stale data never reaches decode
  assign out_inst  = out_valid ? main_inst_q : BUBBLE;
  assign out_pc    = out_valid ? main_pc_q : '0;
  assign in_ready  = in_ready_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed scenarios plus a randomised run against a queue-based model.
module tb_if_id_skid_stage;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] inst;
  } ent_t;

  ent_t mq[$];
  int   mcnt;
  int   n_checks = 0;
  int   n_errors = 0;

  if_id_skid_stage #(
    .DATA_W(DATA_W),
    .PC_W  (PC_W),
    .BUBBLE(32'h0000_0000),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_pc   (out_pc),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a FIFO of capacity two; ready is "fewer than two held at the start of the cycle"
  task automatic tick();
    int sz;
    sz = mq.size();
    if (!rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (sz > 0 && !out_ready && mcnt < CNT_MAX) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (sz > 0 && out_ready) void'(mq.pop_front());
        if (in_valid && sz < 2) mq.push_back('{pc: in_pc, inst: in_inst});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_inst = 32'hDEAD_BEEF; in_pc = 32'h40;
    out_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_inst !== 32'h0) begin n_errors++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
    n_checks++; if (out_pc !== 32'h0) begin n_errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (stall_cnt !== 4'h0) begin n_errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] insts[5];
    rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      insts[i] = $urandom;
      in_valid = 1'b1; in_inst = insts[i]; in_pc = 32'(i * 4);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== insts[i]) begin
        n_errors++;
        $display("FAIL stream_%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, i * 4, insts[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_skid();
    logic [DATA_W-1:0] a, b, c, d;
    a = 32'hA000_000A; b = 32'hB000_000B; c = 32'hC000_000C; d = 32'hD000_000D;
    in_valid = 1'b1; in_inst = a; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    n_checks++; if (out_inst !== a || in_ready !== 1'b1) begin n_errors++; $display("FAIL skid_a_main got inst=%h rdy=%b exp inst=%h rdy=1", out_inst, in_ready, a); end
    in_inst = b; in_pc = 32'h104; out_ready = 1'b0;
    tick();
    n_checks++; if (out_inst !== a || in_ready !== 1'b0) begin n_errors++; $display("FAIL skid_b_skid got inst=%h rdy=%b exp inst=%h rdy=0", out_inst, in_ready, a); end
    in_inst = c; in_pc = 32'h108;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (out_inst !== a || in_ready !== 1'b0) begin n_errors++; $display("FAIL skid_hold_%0d got inst=%h rdy=%b exp inst=%h rdy=0", i, out_inst, in_ready, a); end
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_inst !== b || in_ready !== 1'b1) begin n_errors++; $display("FAIL skid_release_b got inst=%h rdy=%b exp inst=%h rdy=1", out_inst, in_ready, b); end
    tick();
    n_checks++; if (out_inst !== c || out_pc !== 32'h108) begin n_errors++; $display("FAIL skid_c got inst=%h pc=%h exp inst=%h pc=108", out_inst, out_pc, c); end
    in_inst = d; in_pc = 32'h10C;
    tick();
    n_checks++; if (out_inst !== d || out_valid !== 1'b1) begin n_errors++; $display("FAIL skid_d got inst=%h v=%b exp inst=%h v=1", out_inst, out_valid, d); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL skid_empty got=%b exp=0", out_valid); end
    n_checks++; if (stall_cnt !== 4'd3) begin n_errors++; $display("FAIL skid_stall_cnt got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_flush_full();
    logic [DATA_W-1:0] w;
    w = 32'h5555_AAAA;
    in_valid = 1'b1; out_ready = 1'b0; in_inst = 32'h1111_0001; in_pc = 32'h200;
    tick();
    in_inst = 32'h2222_0002; in_pc = 32'h204;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_prefull got rdy=%b exp=0", in_ready); end
    flush = 1'b1; in_inst = 32'h3333_0003; in_pc = 32'h208;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_full got v=%b inst=%h pc=%h rdy=%b exp v=0 inst=0 pc=0 rdy=1", out_valid, out_inst, out_pc, in_ready);
    end
    flush = 1'b0; in_inst = w; in_pc = 32'h300; out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_inst !== w) begin n_errors++; $display("FAIL flush_next_accept got v=%b inst=%h exp v=1 inst=%h", out_valid, out_inst, w); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_dropped got v=%b inst=%h exp v=0", out_valid, out_inst); end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1; in_inst = 32'h7777_0007; in_pc = 32'h400; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (stall_cnt !== 4'hF) begin n_errors++; $display("FAIL sat_cnt got=%h exp=f", stall_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++; if (stall_cnt !== 4'hF || out_valid !== 1'b0) begin n_errors++; $display("FAIL sat_after_flush got cnt=%h v=%b exp cnt=f v=0", stall_cnt, out_valid); end
  endtask

  task automatic test_random();
    ent_t exp_e;
    logic exp_v;
    int   rnd_errors;
    rnd_errors = 0;
    rst = 1'b1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_inst   = $urandom;
      in_pc     = $urandom;
      tick();
      exp_v = (mq.size() > 0);
      if (exp_v) exp_e = mq[0];
      else exp_e = '{pc: '0, inst: 32'h0};
      n_checks++;
      if (out_valid !== exp_v || out_inst !== exp_e.inst || out_pc !== exp_e.pc ||
          in_ready !== (mq.size() < 2) || stall_cnt !== CNT_W'(mcnt)) begin
        n_errors++;
        rnd_errors++;
        if (rnd_errors <= 10)
          $display("FAIL rand_%0d got v=%b inst=%h pc=%h rdy=%b cnt=%0d exp v=%b inst=%h pc=%h rdy=%b cnt=%0d",
                   cyc, out_valid, out_inst, out_pc, in_ready, stall_cnt,
                   exp_v, exp_e.inst, exp_e.pc, (mq.size() < 2), mcnt);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    mcnt = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush_full();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
